// File: rtl/benes_perm_loader.sv
// Collects eight destination indices over valid/ready, flags duplicate destinations,
// and holds the completed map on mp0..mp7 until the consumer acknowledges it.
module benes_perm_loader #(
    parameter int unsigned NUM   = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_dest,
    input  logic             perm_ack,
    output logic             perm_valid,
    output logic             perm_err,
    output logic [3:0]       load_cnt,
    output logic [IDX_W-1:0] mp0,
    output logic [IDX_W-1:0] mp1,
    output logic [IDX_W-1:0] mp2,
    output logic [IDX_W-1:0] mp3,
    output logic [IDX_W-1:0] mp4,
    output logic [IDX_W-1:0] mp5,
    output logic [IDX_W-1:0] mp6,
    output logic [IDX_W-1:0] mp7
);

    typedef enum logic [0:0] {StLoad, StHold} state_e;

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic [NUM-1:0]   seen_q;
    logic             dup_q;
    logic [IDX_W-1:0] mp_q [NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoad;
            cnt_q   <= 4'd0;
            seen_q  <= '0;
            dup_q   <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                mp_q[i] <= '0;
            end
        end else if (clear) begin
            // Abort drops the load bookkeeping but leaves the map registers alone.
            state_q <= StLoad;
            cnt_q   <= 4'd0;
            seen_q  <= '0;
            dup_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (in_valid) begin
                        mp_q[cnt_q[IDX_W-1:0]] <= in_dest;
                        seen_q[in_dest]        <= 1'b1;
                        if (seen_q[in_dest]) begin
                            dup_q <= 1'b1;
                        end
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'(NUM - 1)) begin
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (perm_ack) begin
                        state_q <= StLoad;
                        cnt_q   <= 4'd0;
                        seen_q  <= '0;
                        dup_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // All outputs decode registered state only; no input reaches them combinationally.
    assign in_ready   = (state_q == StLoad);
    assign perm_valid = (state_q == StHold);
    assign perm_err   = perm_valid & dup_q;
    assign load_cnt   = cnt_q;

    assign mp0 = mp_q[0];
    assign mp1 = mp_q[1];
    assign mp2 = mp_q[2];
    assign mp3 = mp_q[3];
    assign mp4 = mp_q[4];
    assign mp5 = mp_q[5];
    assign mp6 = mp_q[6];
    assign mp7 = mp_q[7];

endmodule

// File: tb/tb_benes_perm_loader.sv
// Self-checking bench for benes_perm_loader: directed vector table, async reset sequence,
// and randomized traffic against a queue-based model of the loader.
module tb_benes_perm_loader;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_dest;
    logic       perm_ack;
    logic       perm_valid;
    logic       perm_err;
    logic [3:0] load_cnt;
    logic [2:0] mp0, mp1, mp2, mp3, mp4, mp5, mp6, mp7;

    benes_perm_loader #(.NUM(8), .IDX_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dest    (in_dest),
        .perm_ack   (perm_ack),
        .perm_valid (perm_valid),
        .perm_err   (perm_err),
        .load_cnt   (load_cnt),
        .mp0        (mp0),
        .mp1        (mp1),
        .mp2        (mp2),
        .mp3        (mp3),
        .mp4        (mp4),
        .mp5        (mp5),
        .mp6        (mp6),
        .mp7        (mp7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the list of destinations accepted in the current load.
    bit   m_hold;
    int   m_q[$];
    logic [2:0] m_mp[8];

    typedef struct {
        bit         v;
        logic [2:0] d;
        bit         ack;
        bit         clr;
        bit         ev;
        bit         ee;
        logic [3:0] ec;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s idx=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_hold = 1'b0;
        m_q.delete();
        for (int i = 0; i < 8; i++) m_mp[i] = 3'd0;
    endfunction

    function automatic void model_step(input bit v, input logic [2:0] d, input bit a,
                                       input bit c);
        if (c) begin
            m_hold = 1'b0;
            m_q.delete();
        end else if (!m_hold) begin
            if (v) begin
                m_mp[m_q.size()] = d;
                m_q.push_back(int'(d));
                if (m_q.size() == 8) m_hold = 1'b1;
            end
        end else if (a) begin
            m_hold = 1'b0;
            m_q.delete();
        end
    endfunction

    function automatic logic [63:0] model_vec();
        logic [7:0] used;
        bit err;
        used = 8'h00;
        foreach (m_q[i]) used[m_q[i]] = 1'b1;
        err = m_hold && (used != 8'hFF);
        return {33'd0, m_hold, err, ~m_hold, 4'(m_q.size()),
                m_mp[7], m_mp[6], m_mp[5], m_mp[4], m_mp[3], m_mp[2], m_mp[1], m_mp[0]};
    endfunction

    function automatic logic [63:0] dut_vec();
        return {33'd0, perm_valid, perm_err, in_ready, load_cnt,
                mp7, mp6, mp5, mp4, mp3, mp2, mp1, mp0};
    endfunction

    task automatic cycle(input string name, input int idx, input bit v, input logic [2:0] d,
                         input bit a, input bit c);
        in_valid = v;
        in_dest  = d;
        perm_ack = a;
        clear    = c;
        @(posedge clk);
        model_step(v, d, a, c);
        #1;
        chk(name, idx, dut_vec(), model_vec());
    endtask

    function automatic void add(input bit v, input int d, input bit ack, input bit clr,
                                input bit ev, input bit ee, input int ec);
        vec_t r;
        r.v = v; r.d = 3'(d); r.ack = ack; r.clr = clr;
        r.ev = ev; r.ee = ee; r.ec = 4'(ec);
        tbl.push_back(r);
    endfunction

    int perm[8];

    function automatic void shuffle();
        for (int i = 0; i < 8; i++) perm[i] = i;
        for (int i = 7; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
    endfunction

    initial begin
        int dup_seq[8];
        int ok_seq[8];
        dup_seq = '{3, 1, 3, 0, 2, 4, 5, 6};
        ok_seq  = '{2, 0, 1, 3, 4, 5, 6, 7};

        // Identity, held for two extra cycles, then ack.
        for (int i = 0; i < 8; i++) add(1, i, 0, 0, i == 7, 0, i + 1);
        add(0, 0, 0, 0, 1, 0, 8);
        add(0, 0, 0, 0, 1, 0, 8);
        add(0, 0, 1, 0, 0, 0, 0);
        // Reverse map with bubbles.
        for (int i = 0; i < 8; i++) begin
            add(1, 7 - i, 0, 0, i == 7, 0, i + 1);
            add(0, i, 0, 0, i == 7, 0, i + 1);
        end
        // Back-pressure during HOLD, then ack.
        for (int i = 0; i < 4; i++) add(1, 5, 0, 0, 1, 0, 8);
        add(0, 0, 1, 0, 0, 0, 0);
        // Duplicate load, then a valid load.
        for (int i = 0; i < 8; i++) add(1, dup_seq[i], 0, 0, i == 7, i == 7, i + 1);
        add(0, 0, 0, 0, 1, 1, 8);
        add(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, ok_seq[i], 0, 0, i == 7, 0, i + 1);
        add(0, 0, 1, 0, 0, 0, 0);
        // Clear mid-load with a beat presented; fresh load must not see stale bits.
        for (int i = 0; i < 5; i++) add(1, i, 0, 0, 0, 0, i + 1);
        add(1, 5, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, (i + 4) % 8, 0, 0, i == 7, 0, i + 1);
        // Clear beats ack in HOLD; ack outside HOLD is ignored.
        add(0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        // Duplicate load left in HOLD for the reset test.
        for (int i = 0; i < 8; i++) add(1, (i == 0) ? 1 : i, 0, 0, i == 7, i == 7, i + 1);

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_dest = 3'd0; perm_ack = 1'b0;
        model_reset();
        #12;
        chk("reset_state", 0, dut_vec(), model_vec());
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_release_ready", 0, 64'(in_ready), 64'd1);

        foreach (tbl[i]) begin
            cycle("table_model", i, tbl[i].v, tbl[i].d, tbl[i].ack, tbl[i].clr);
            chk("table_vec", i, {perm_valid, perm_err, load_cnt}, {tbl[i].ev, tbl[i].ee, tbl[i].ec});
        end
        chk("dup_err_before_reset", 0, 64'(perm_err), 64'd1);

        // Async reset in HOLD, asserted between edges.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_outputs", 0, dut_vec(),
            {33'd0, 1'b0, 1'b0, 1'b1, 4'd0, 24'd0});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("async_reset_release", 0, {in_ready, perm_valid, load_cnt}, {1'b1, 1'b0, 4'd0});

        // Randomized traffic; mostly true permutations with occasional random dests.
        shuffle();
        for (int n = 0; n < 1500; n++) begin
            bit v, a, c;
            logic [2:0] d;
            if (m_q.size() == 0 && !m_hold) shuffle();
            v = ($urandom_range(9, 0) < 7);
            a = ($urandom_range(9, 0) < 3);
            c = ($urandom_range(99, 0) < 3);
            if ($urandom_range(5, 0) == 0) d = 3'($urandom_range(7, 0));
            else d = 3'(perm[m_q.size() % 8]);
            cycle("random", n, v, d, a, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/benes_perm_loader.md
Name: benes_perm_loader

Overview:
- Upstream feeder for the 8-port Benes permutation path.
- Collects destination indices one per accepted beat over a valid/ready handshake, in source order 0..7.
- Checks on the fly that the 8 indices form a true permutation, with no duplicate destination.
- Presents the collected map in parallel on mp0..mp7 with perm_valid/perm_err for the inverse-permutation stage, and holds it until acknowledged.

Parameters:
- NUM, 8, number of ports. Fixed for this revision; other values unsupported.
- IDX_W, 3, index width, log2(NUM). Fixed for this revision.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort; discards a partial or complete load
- in_valid  input  1  in_dest carries a valid destination index
- in_ready  output  1  loader can accept a beat
- in_dest  input  3  destination port for the current source index
- perm_ack  input  1  consumer has taken the presented permutation
- perm_valid  output  1  mp0..mp7 hold a complete 8-entry load
- perm_err  output  1  qualified by perm_valid; load contained a duplicate destination
- load_cnt  output  4  number of beats accepted in the current load, 0..8
- mp0..mp7  output  3 each  destination of source i, registered

Behaviour:
- Reset (rst_n low, async):
  - state=LOAD, load_cnt=0, seen mask=8'h00, dup flag=0.
  - perm_valid=0, perm_err=0, all mp outputs=3'd0.
  - in_ready is 1 once reset deasserts.
- Two states, LOAD and HOLD.
- LOAD:
  - in_ready=1, perm_valid=0.
  - Accept happens when in_valid & in_ready at the clock edge.
  - On accept: mp[load_cnt] <= in_dest; seen[in_dest] <= 1; if seen[in_dest] was already 1, dup <= 1 (sticky); load_cnt <= load_cnt+1.
  - The duplicate check uses the registered seen mask only; the current beat's own bit does not count against itself.
  - The accept that brings load_cnt to 8 moves state to HOLD on that same edge.
- HOLD:
  - in_ready=0, perm_valid=1, perm_err=dup, load_cnt=8.
  - mp0..mp7 stay stable for the whole HOLD interval.
  - in_valid is ignored; no beat is accepted.
  - perm_ack=1 at the edge: state <= LOAD, load_cnt <= 0, seen <= 0, dup <= 0.
  - The next cycle shows perm_valid=0, in_ready=1.
  - mp outputs keep their old values until each slot is overwritten by the new load.
- Latency: perm_valid rises the cycle after the 8th accept. Minimum per-load cycle is 8 accept cycles + 1 HOLD cycle with immediate ack.
- perm_ack outside HOLD: ignored.
- clear:
  - Highest priority; wins over accept and ack in the same cycle.
  - Next state LOAD, load_cnt=0, seen=0, dup=0, perm_valid=0.
  - mp registers are not cleared.
  - Any beat presented in the clear cycle is dropped, even though in_ready reads 1.
- Without duplicates, 8 accepted beats imply the seen mask is 8'hFF. perm_err is thus exactly "not a permutation".
- perm_err is 0 whenever perm_valid is 0.
- No combinational path from in_valid or perm_ack to any output; in_ready is decoded from state only.
- Reset asserted mid-load or mid-HOLD returns immediately to the reset values above.

Test Plan:
- Identity load: beats 0,1,...,7 back-to-back with perm_ack held 0 → perm_valid=1 from the cycle after the 8th accept; mp_i=i; perm_err=0; in_ready=0 and load_cnt=8 while held.
- Reverse map with bubbles: in_dest 7,6,5,4,3,2,1,0 with in_valid low on alternate cycles → only 8 accepts counted; mp_i=7-i; perm_err=0.
- Duplicate: beats 3,1,3,0,2,4,5,6 → perm_valid=1, perm_err=1, mp0=3, mp2=3. Then ack and load the valid map 2,0,1,3,4,5,6,7 → perm_err=0.
- Ack and back-pressure: during HOLD drive in_valid=1 with dest=5 for 4 cycles → no accept, outputs unchanged. Pulse perm_ack → in_ready=1 next cycle, load_cnt=0, mp unchanged until rewritten.
- clear mid-load: after 5 beats (load_cnt=5) assert clear together with in_valid → load_cnt=0, beat dropped. A fresh 8-beat load then completes normally with a correct dup check (no stale seen bits).
- Async reset: assert rst_n=0 in HOLD with perm_err=1 → immediately perm_valid=0, perm_err=0, mp all 0, load_cnt=0. After release in_ready=1.
